tt_sweep_ctrl: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_settle_timer.sv | 29 ++
 rtl/tt_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
// Imported by tt_settle_timer and tt_sweep_ctrl.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } sweep_state_e;

  localparam int TT_ROWS = 16;
  localparam int ROW_W   = 4;
  localparam int ERR_W   = 5;

  // Row i = {in1,in2,in3,in4} with in1 as MSB, so row 0 lives in the table MSB.
  function automatic logic tt_expected(input logic [TT_ROWS-1:0] tbl,
                                       input logic [ROW_W-1:0]   row);
    return tbl[4'd15 - row];
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector settle counter: counts while enabled, flags the last settle cycle
// and wraps to zero on that cycle so the next row starts a fresh count.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = 8;

  logic [CW-1:0] r_count;

  assign o_term = i_en && (r_count == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_term ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input gate network and checks each row
// against TRUTH_TABLE. Define TT_SWEEP_FIRST_FAIL_STOP_EN to end on first mismatch.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE   = 16'h0760,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_mask,
  output logic [4:0]  err_count,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a level sampled on the rising edge and only accepted in
  // IDLE; abort is only honoured in SETTLE; done is high for exactly the one
  // DONE cycle; results hold until the next accepted start.

  sweep_state_e       r_state, w_state_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [ROW_W-1:0]   r_vec, w_vec_nxt;
  logic [TT_ROWS-1:0] r_mask, w_mask_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic               r_pass, w_pass_nxt;
  logic               w_timer_clr;
  logic               w_timer_en;
  logic               w_term;
  logic               w_miss;
  logic               w_last;

  assign w_timer_en = (r_state == ST_SETTLE);
  assign w_last     = (r_row == ROW_W'(TT_ROWS - 1));

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_timer_clr),
    .i_en   (w_timer_en),
    .o_term (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err;
    w_pass_nxt  = r_pass;
    w_timer_clr = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_row_nxt   = '0;
          w_mask_nxt  = '0;
          w_err_nxt   = '0;
          w_pass_nxt  = 1'b0;
          w_timer_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_term) begin
          w_miss = (dut_out != tt_expected(TRUTH_TABLE, r_row));
          if (w_miss) begin
            w_mask_nxt[r_row] = 1'b1;
            if (r_err != ERR_W'(TT_ROWS)) w_err_nxt = r_err + ERR_W'(1);
          end
`ifdef TT_SWEEP_FIRST_FAIL_STOP_EN
          if (w_miss || w_last) begin
`else
          if (w_last) begin
`endif
            w_state_nxt = ST_DONE;
            w_pass_nxt  = (w_err_nxt == '0);
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The vector is registered so the network sees clean edges; it is zero
  // whenever the controller is not settling a row.
  assign w_vec_nxt = (w_state_nxt == ST_SETTLE) ? w_row_nxt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_vec   <= '0;
      r_mask  <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_vec   <= w_vec_nxt;
      r_mask  <= w_mask_nxt;
      r_err   <= w_err_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign in1           = r_vec[3];
  assign in2           = r_vec[2];
  assign in3           = r_vec[1];
  assign in4           = r_vec[0];
  assign busy          = (r_state == ST_SETTLE);
  assign done          = (r_state == ST_DONE);
  assign pass          = r_pass;
  assign mismatch_mask = r_mask;
  assign err_count     = r_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: behavioural gate-network models drive dut_out;
// a table of full sweeps plus hand sequences for abort, reset and re-start.
module tb_tt_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (SETTLE_CYCLES=4) and DUT B (SETTLE_CYCLES=2) ----
  logic        a_start = 1'b0, a_abort = 1'b0, a_dut_out;
  logic        a_in1, a_in2, a_in3, a_in4, a_busy, a_done, a_pass;
  logic [15:0] a_mask;
  logic [4:0]  a_err;
  logic [1:0]  a_dbg;
  logic        b_start = 1'b0, b_abort = 1'b0, b_dut_out;
  logic        b_in1, b_in2, b_in3, b_in4, b_busy, b_done, b_pass;
  logic [15:0] b_mask;
  logic [4:0]  b_err;
  logic [1:0]  b_dbg;

  tt_sweep_ctrl #(.TRUTH_TABLE(16'h0760), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .dut_out(a_dut_out),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .in4(a_in4), .busy(a_busy), .done(a_done),
    .pass(a_pass), .mismatch_mask(a_mask), .err_count(a_err), .dbg_state(a_dbg));

  tt_sweep_ctrl #(.TRUTH_TABLE(16'h0760), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .dut_out(b_dut_out),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4), .busy(b_busy), .done(b_done),
    .pass(b_pass), .mismatch_mask(b_mask), .err_count(b_err), .dbg_state(b_dbg));

  // ---------------- gate network models ----------------
  // mode: 0 ideal, 1 stuck-at-0, 2 three-cycle delayed, 3 stuck-at-1, 4 inverted
  int         mode = 0;
  logic       bsel = 1'b0;
  logic [3:0] a_vec, b_vec;
  logic [2:0] a_pipe = '0, b_pipe = '0;

  assign a_vec = {a_in1, a_in2, a_in3, a_in4};
  assign b_vec = {b_in1, b_in2, b_in3, b_in4};

  function automatic logic ideal_fn(input logic [3:0] v);
    return (v == 4'd5) || (v == 4'd6) || (v == 4'd7) || (v == 4'd9) || (v == 4'd10);
  endfunction

  always @(posedge clk) begin
    a_pipe <= {a_pipe[1:0], ideal_fn(a_vec)};
    b_pipe <= {b_pipe[1:0], ideal_fn(b_vec)};
  end

  always_comb begin
    case (mode)
      1:       a_dut_out = 1'b0;
      2:       a_dut_out = a_pipe[2];
      3:       a_dut_out = 1'b1;
      4:       a_dut_out = ~ideal_fn(a_vec);
      default: a_dut_out = ideal_fn(a_vec);
    endcase
  end
  assign b_dut_out = b_pipe[2];

  logic [3:0]  w_vec;
  logic        w_busy, w_done, w_pass;
  logic [15:0] w_mask;
  logic [4:0]  w_err;
  assign w_vec  = bsel ? b_vec  : a_vec;
  assign w_busy = bsel ? b_busy : a_busy;
  assign w_done = bsel ? b_done : a_done;
  assign w_pass = bsel ? b_pass : a_pass;
  assign w_mask = bsel ? b_mask : a_mask;
  assign w_err  = bsel ? b_err  : a_err;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic sel, input logic v);
    if (sel) b_start = v;
    else     a_start = v;
  endtask

  // Runs one sweep; checks the vector sequence, done timing, one-cycle done
  // and that a start pulsed while busy / in DONE does not restart anything.
  task automatic run_sweep(input logic sel, input int mode_i, input int s,
                           input int exp_k, input bit repulse, input string tag);
    int k;
    int bad;
    int done_k;
    bsel = sel;
    mode = mode_i;
    @(negedge clk);
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    k = 0; bad = 0; done_k = -1;
    while (k <= exp_k + 8) begin
      if (w_done) begin
        done_k = k;
        break;
      end
      if (w_vec !== 4'(k / s) || w_busy !== 1'b1) bad++;
      drive_start(sel, repulse && (k == 10));
      @(negedge clk);
      k++;
    end
    chk({tag, "_vec_seq_errs"}, bad, 0);
    chk({tag, "_done_cycle"}, done_k, exp_k);
    chk({tag, "_busy_in_done"}, {31'd0, w_busy}, 0);
    drive_start(sel, repulse);
    @(negedge clk);
    drive_start(sel, 1'b0);
    chk({tag, "_done_one_cycle"}, {31'd0, w_done}, 0);
    @(negedge clk);
    chk({tag, "_no_restart"}, {31'd0, w_busy}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    int          mode;
    int          settle;
    int          exp_k;
    bit          repulse;
    logic        exp_pass;
    logic [15:0] exp_mask;
    logic [4:0]  exp_err;
  } vec_t;

  vec_t tbl[7];

`ifdef TT_SWEEP_FIRST_FAIL_STOP_EN
  localparam int ABORT_ROW = 4;
  localparam logic [15:0] ABORT_MASK = 16'h0000;
  localparam int ABORT_ERR = 0;
`else
  localparam int ABORT_ROW = 7;
  localparam logic [15:0] ABORT_MASK = 16'h0060;
  localparam int ABORT_ERR = 2;
`endif

  initial begin
    int dcnt;
    tbl[0] = '{1'b0, 0, 4, 64, 1'b0, 1'b1, 16'h0000, 5'd0};
`ifdef TT_SWEEP_FIRST_FAIL_STOP_EN
    tbl[1] = '{1'b0, 1, 4, 24, 1'b0, 1'b0, 16'h0020, 5'd1};
    tbl[2] = '{1'b0, 3, 4,  4, 1'b0, 1'b0, 16'h0001, 5'd1};
    tbl[3] = '{1'b0, 4, 4,  4, 1'b0, 1'b0, 16'h0001, 5'd1};
    tbl[5] = '{1'b1, 2, 2, 12, 1'b0, 1'b0, 16'h0020, 5'd1};
`else
    tbl[1] = '{1'b0, 1, 4, 64, 1'b0, 1'b0, 16'h06E0, 5'd5};
    tbl[2] = '{1'b0, 3, 4, 64, 1'b0, 1'b0, 16'hF91F, 5'd11};
    tbl[3] = '{1'b0, 4, 4, 64, 1'b0, 1'b0, 16'hFFFF, 5'd16};
    tbl[5] = '{1'b1, 2, 2, 32, 1'b0, 1'b0, 16'h0B20, 5'd4};
`endif
    tbl[4] = '{1'b0, 2, 4, 64, 1'b0, 1'b1, 16'h0000, 5'd0};
    tbl[6] = '{1'b0, 0, 4, 64, 1'b1, 1'b1, 16'h0000, 5'd0};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_a_vec", a_vec, 0);
    chk("rst_a_busy_done_pass", {a_busy, a_done, a_pass}, 0);
    chk("rst_a_mask", a_mask, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_state", a_dbg, 0);
    chk("rst_b_all", {b_vec, b_busy, b_done, b_pass, b_mask, b_err, b_dbg}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].sel, tbl[i].mode, tbl[i].settle, tbl[i].exp_k, tbl[i].repulse,
                $sformatf("v%0d", i));
      chk($sformatf("v%0d_pass", i), {31'd0, w_pass}, {31'd0, tbl[i].exp_pass});
      chk($sformatf("v%0d_mask", i), w_mask, tbl[i].exp_mask);
      chk($sformatf("v%0d_err", i), w_err, tbl[i].exp_err);
    end

    // start and abort together in IDLE, then abort mid-row
    bsel = 1'b0;
    mode = 1;
    @(negedge clk);
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b0;
    chk("start_beats_abort", {31'd0, a_busy}, 1);
    repeat (ABORT_ROW * 4 + 1) @(negedge clk);
    chk("abort_row_vec", a_vec, ABORT_ROW);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_busy", {31'd0, a_busy}, 0);
    chk("abort_state", a_dbg, 0);
    chk("abort_vec", a_vec, 0);
    dcnt = 0;
    repeat (80) begin
      if (a_done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_pass", {31'd0, a_pass}, 0);
    chk("abort_mask", a_mask, ABORT_MASK);
    chk("abort_err", a_err, ABORT_ERR);

    // asynchronous reset during row 10
    mode = 0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (42) @(negedge clk);
    chk("pre_rst_vec", a_vec, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_vec", a_vec, 0);
    chk("midrst_flags", {a_busy, a_done, a_pass}, 0);
    chk("midrst_state", a_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, 0, 4, 64, 1'b0, "post_rst");
    chk("post_rst_pass", {31'd0, a_pass}, 1);
    chk("post_rst_mask", a_mask, 16'h0000);
    chk("post_rst_err", a_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
